// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_pkg
// Description : Shared types and constants for the hazard scheduler.
//               Contains the scheduler state enum, the scoreboard entry type,
//               and the scoreboard depth, drain length and branch timeout.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    localparam int SB_DEPTH     = 3;
    localparam int DRAIN_CYCLES = 3;
    localparam int BR_TIMEOUT   = 7;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_BR_WAIT = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_HALTED  = 2'd3
    } state_t;

    // One in-flight register write: valid, destination, produced by a load
    typedef struct packed {
        logic       v;
        logic [2:0] rd;
        logic       ld;
    } sb_entry_t;

endpackage
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : Three-stage shift pipe of in-flight register writes plus the
//               RAW compare against the decode-stage source registers.
//               Stage 3 is covered by the register-file bypass, so only
//               stages 1 and 2 take part in the compare.
//               Build option HAZARD_FWD_EN: an ALU forwarding path exists, so
//               only a load in stage 1 can cause a hazard (load-use).
// Ports       : clk, rst (sync, active-low)
//               i_valid, i_rs, i_rt, i_rs_used, i_rt_used  - decode sources
//               i_regwrt, i_memread, i_rd                  - decode write info
//               i_run                                      - scheduler in RUN
//               o_hazard                                   - RAW hazard now
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
    import hazard_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_valid,
    input  logic [2:0] i_rs,
    input  logic [2:0] i_rt,
    input  logic       i_rs_used,
    input  logic       i_rt_used,
    input  logic       i_regwrt,
    input  logic       i_memread,
    input  logic [2:0] i_rd,
    input  logic       i_run,
    output logic       o_hazard
);

    sb_entry_t r_sb [SB_DEPTH];
    logic      w_hit1;

    function automatic logic src_hit(sb_entry_t e, logic [2:0] s, logic used);
        return used && e.v && (e.rd == s);
    endfunction

    always_comb begin
        w_hit1 = src_hit(r_sb[0], i_rs, i_rs_used) | src_hit(r_sb[0], i_rt, i_rt_used);
    end

`ifdef HAZARD_FWD_EN
    // Forwarding covers ALU results; only a load one stage ahead must stall
    assign o_hazard = i_valid & i_run & w_hit1 & r_sb[0].ld;
`else
    logic w_hit2;

    always_comb begin
        w_hit2 = src_hit(r_sb[1], i_rs, i_rs_used) | src_hit(r_sb[1], i_rt, i_rt_used);
    end

    assign o_hazard = i_valid & i_run & (w_hit1 | w_hit2);
`endif

    // A stalled or non-RUN decode enters the pipe as a bubble
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < SB_DEPTH; i++) begin
                r_sb[i] <= '0;
            end
        end else begin
            r_sb[0].v  <= i_valid & i_regwrt & ~o_hazard & i_run;
            r_sb[0].rd <= i_rd;
            r_sb[0].ld <= i_memread;
            for (int i = 1; i < SB_DEPTH; i++) begin
                r_sb[i] <= r_sb[i-1];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/hazard_sched.sv
`default_nettype none
// ============================================================================
// Module      : hazard_sched
// Description : Pipeline hazard scheduler. Stalls decode on RAW hazards,
//               flushes fetch while a branch resolves (with a sticky timeout
//               error), drains the pipe on HALT and counts stall cycles.
//               Build option HAZARD_FWD_EN selects load-use-only stalls.
// Ports       : clk, rst (sync, active-low)
//               id_*        - decode-stage instruction information
//               br_resolve  - execute has resolved the outstanding branch
//               nop_mech    - force decode control to NOP
//               pc_hold     - freeze PC and IF/ID register
//               if_flush    - squash the fetched instruction
//               halted      - pipeline drained after HALT
//               err         - sticky branch-timeout error
//               stall_cnt   - saturating RAW-stall cycle count
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_sched
    import hazard_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [2:0]  id_rs,
    input  logic [2:0]  id_rt,
    input  logic        id_rs_used,
    input  logic        id_rt_used,
    input  logic        id_regwrt,
    input  logic        id_memread,
    input  logic [2:0]  id_rd,
    input  logic        id_branch,
    input  logic        id_halt,
    input  logic        br_resolve,
    output logic        nop_mech,
    output logic        pc_hold,
    output logic        if_flush,
    output logic        halted,
    output logic        err,
    output logic [15:0] stall_cnt
);

    localparam logic [2:0] c_br_last    = 3'(BR_TIMEOUT - 1);
    localparam logic [2:0] c_drain_last = 3'(DRAIN_CYCLES - 1);

    state_t      r_state;
    logic [2:0]  r_cnt;
    logic        r_err;
    logic [15:0] r_stall_cnt;
    logic        w_hazard;
    logic        w_run;

    assign w_run = (r_state == ST_RUN);

    hazard_scoreboard u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .i_valid   (id_valid),
        .i_rs      (id_rs),
        .i_rt      (id_rt),
        .i_rs_used (id_rs_used),
        .i_rt_used (id_rt_used),
        .i_regwrt  (id_regwrt),
        .i_memread (id_memread),
        .i_rd      (id_rd),
        .i_run     (w_run),
        .o_hazard  (w_hazard)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_RUN;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            if (w_hazard && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            case (r_state)
                ST_RUN: begin
                    r_cnt <= '0;
                    // Hazard wins: the instruction is held and re-evaluated
                    if (!w_hazard) begin
                        if (id_valid && id_halt) begin
                            r_state <= ST_DRAIN;
                        end else if (id_valid && id_branch) begin
                            r_state <= ST_BR_WAIT;
                        end
                    end
                end
                ST_BR_WAIT: begin
                    if (br_resolve) begin
                        r_state <= ST_RUN;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_br_last) begin
                        r_err   <= 1'b1;
                        r_state <= ST_RUN;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                ST_DRAIN: begin
                    // Scoreboard has shifted out every write after these cycles
                    if (r_cnt == c_drain_last) begin
                        r_state <= ST_HALTED;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                ST_HALTED: begin
                    r_state <= ST_HALTED;
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    assign nop_mech  = w_hazard | ~w_run;
    assign pc_hold   = w_hazard | (r_state == ST_DRAIN) | (r_state == ST_HALTED);
    assign if_flush  = (r_state == ST_BR_WAIT);
    assign halted    = (r_state == ST_HALTED);
    assign err       = r_err;
    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_sched
// Description : Self-checking bench for hazard_sched. A reference model built
//               from a per-cycle history of issued writes predicts outputs;
//               predictions are queued and a negedge monitor compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_sched;

    localparam int M_RUN = 0;
    localparam int M_BRW = 1;
    localparam int M_DRN = 2;
    localparam int M_HLT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [2:0]  id_rs, id_rt, id_rd;
    logic        id_rs_used, id_rt_used, id_regwrt, id_memread;
    logic        id_branch, id_halt, br_resolve;
    logic        nop_mech, pc_hold, if_flush, halted, err;
    logic [15:0] stall_cnt;

    always #5 clk = ~clk;

    hazard_sched dut (
        .clk        (clk),
        .rst        (rst),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_rs_used (id_rs_used),
        .id_rt_used (id_rt_used),
        .id_regwrt  (id_regwrt),
        .id_memread (id_memread),
        .id_rd      (id_rd),
        .id_branch  (id_branch),
        .id_halt    (id_halt),
        .br_resolve (br_resolve),
        .nop_mech   (nop_mech),
        .pc_hold    (pc_hold),
        .if_flush   (if_flush),
        .halted     (halted),
        .err        (err),
        .stall_cnt  (stall_cnt)
    );

    typedef struct packed {
        logic        nop;
        logic        hold;
        logic        flush;
        logic        hlt;
        logic        er;
        logic [15:0] stall;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    int   m_mode  = M_RUN;
    int   m_k     = 0;
    logic m_err   = 1'b0;
    int   m_stall = 0;
    int   cyc     = 0;
    int   last_rst = 0;
    logic       hist_v  [int];
    logic [2:0] hist_rd [int];
    logic       hist_ld [int];

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, expv);
        end
    endtask

    // Write issued 'age' cycles ago targeting register s (and optionally a load)
    function automatic logic pending(int age, logic [2:0] s, logic need_ld);
        int t;
        t = cyc - age;
        if (t <= last_rst || !hist_v.exists(t)) return 1'b0;
        return hist_v[t] && (hist_rd[t] == s) && (!need_ld || hist_ld[t]);
    endfunction

    function automatic logic src_blocked(logic [2:0] s);
`ifdef HAZARD_FWD_EN
        return pending(1, s, 1'b1);
`else
        return pending(1, s, 1'b0) || pending(2, s, 1'b0);
`endif
    endfunction

    function automatic logic m_hazard();
        if (!(id_valid && m_mode == M_RUN)) return 1'b0;
        return (id_rs_used && src_blocked(id_rs)) || (id_rt_used && src_blocked(id_rt));
    endfunction

    // One clock: predict this cycle's outputs, advance the model, clock the DUT
    task automatic tick();
        exp_t e;
        logic hz;
        hz      = m_hazard();
        e.nop   = hz || (m_mode != M_RUN);
        e.hold  = hz || (m_mode == M_DRN) || (m_mode == M_HLT);
        e.flush = (m_mode == M_BRW);
        e.hlt   = (m_mode == M_HLT);
        e.er    = m_err;
        e.stall = 16'(m_stall);
        exp_q.push_back(e);
        if (!rst) begin
            m_mode = M_RUN; m_k = 0; m_err = 1'b0; m_stall = 0; last_rst = cyc;
        end else begin
            if (hz && m_stall < 65535) m_stall++;
            hist_v[cyc]  = id_valid && id_regwrt && !hz && (m_mode == M_RUN);
            hist_rd[cyc] = id_rd;
            hist_ld[cyc] = id_memread;
            case (m_mode)
                M_RUN: begin
                    if (!hz && id_valid && id_halt) begin m_mode = M_DRN; m_k = 1; end
                    else if (!hz && id_valid && id_branch) begin m_mode = M_BRW; m_k = 1; end
                end
                M_BRW: begin
                    if (br_resolve) m_mode = M_RUN;
                    else if (m_k == 7) begin m_err = 1'b1; m_mode = M_RUN; end
                    else m_k++;
                end
                M_DRN: begin
                    if (m_k == 3) m_mode = M_HLT;
                    else m_k++;
                end
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_idle();
        id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0;
        id_rs_used = 0; id_rt_used = 0; id_regwrt = 0; id_memread = 0;
        id_branch = 0; id_halt = 0; br_resolve = 0;
    endtask

    task automatic do_write(input logic [2:0] rd, input logic ld);
        set_idle(); id_valid = 1; id_regwrt = 1; id_rd = rd; id_memread = ld;
        tick();
    endtask

    task automatic do_read(input logic [2:0] rs, input int n);
        set_idle(); id_valid = 1; id_rs = rs; id_rs_used = 1;
        repeat (n) tick();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("nop_mech",  int'(nop_mech),  int'(e.nop));
            chk("pc_hold",   int'(pc_hold),   int'(e.hold));
            chk("if_flush",  int'(if_flush),  int'(e.flush));
            chk("halted",    int'(halted),    int'(e.hlt));
            chk("err",       int'(err),       int'(e.er));
            chk("stall_cnt", int'(stall_cnt), int'(e.stall));
        end
    end

    initial begin
        int base;
        set_idle();
        rst = 0;
        @(posedge clk); #1;
        tick(); tick();
        rst = 1;
        chk("reset_stall", int'(stall_cnt), 0);

        // RAW on the very next cycle
        base = int'(stall_cnt);
        do_write(3'd3, 1'b0);
        do_read(3'd3, 3);
`ifdef HAZARD_FWD_EN
        chk("raw_alu_stalls", int'(stall_cnt) - base, 0);
`else
        chk("raw_alu_stalls", int'(stall_cnt) - base, 2);
`endif

        // Load-use
        base = int'(stall_cnt);
        do_write(3'd2, 1'b1);
        do_read(3'd2, 3);
`ifdef HAZARD_FWD_EN
        chk("load_use_stalls", int'(stall_cnt) - base, 1);
`else
        chk("load_use_stalls", int'(stall_cnt) - base, 2);
`endif

        // Branch resolved after a few wait cycles
        set_idle(); id_valid = 1; id_branch = 1; tick();
        set_idle(); tick(); tick();
        br_resolve = 1; tick();
        set_idle(); tick();
        chk("branch_back_run", int'(if_flush), 0);

        // Branch resolved in the BR_WAIT entry cycle
        set_idle(); id_valid = 1; id_branch = 1; tick();
        set_idle(); br_resolve = 1; tick();
        set_idle(); tick();

        // Branch timeout, err sticky afterwards
        set_idle(); id_valid = 1; id_branch = 1; tick();
        set_idle(); repeat (9) tick();
        chk("br_timeout_err", int'(err), 1);
        chk("br_timeout_run", int'(if_flush), 0);

        // Halt with writes in flight
        do_write(3'd1, 1'b0);
        do_write(3'd5, 1'b1);
        set_idle(); id_valid = 1; id_halt = 1; tick();
        set_idle(); repeat (5) tick();
        chk("halted_set", int'(halted), 1);
        rst = 0; tick(); rst = 1;
        chk("halted_cleared", int'(halted), 0);
        chk("err_cleared", int'(err), 0);

        // Reset abandons BR_WAIT and DRAIN
        set_idle(); id_valid = 1; id_branch = 1; tick();
        set_idle(); tick();
        rst = 0; tick(); rst = 1;
        chk("rst_mid_branch", int'(if_flush), 0);
        set_idle(); id_valid = 1; id_halt = 1; tick();
        set_idle(); tick();
        rst = 0; tick(); rst = 1;
        chk("rst_mid_drain", int'(pc_hold), 0);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 59) != 0);
            id_valid   = ($urandom_range(0, 5) != 0);
            id_rs      = 3'($urandom_range(0, 7));
            id_rt      = 3'($urandom_range(0, 7));
            id_rd      = 3'($urandom_range(0, 7));
            id_rs_used = 1'($urandom_range(0, 1));
            id_rt_used = 1'($urandom_range(0, 1));
            id_regwrt  = ($urandom_range(0, 3) != 0);
            id_memread = 1'($urandom_range(0, 1));
            id_branch  = ($urandom_range(0, 11) == 0);
            id_halt    = ($urandom_range(0, 79) == 0);
            br_resolve = ($urandom_range(0, 4) == 0);
            tick();
        end

        // Saturation: hold the hazard asserted for 70000 cycles
        set_idle(); rst = 0; tick(); rst = 1; tick();
        @(negedge clk);
        chk("sat_start", int'(stall_cnt), 0);
        force dut.w_hazard = 1'b1;
        repeat (65534) @(posedge clk);
        @(negedge clk);
        chk("sat_before_top", int'(stall_cnt), 16'hFFFE);
        repeat (70000 - 65534) @(posedge clk);
        @(negedge clk);
        chk("sat_stall_cnt", int'(stall_cnt), 16'hFFFF);
        chk("sat_pc_hold", int'(pc_hold), 1);
        release dut.w_hazard;
        rst = 0;
        @(posedge clk); #1;
        rst = 1;
        chk("sat_reset_clears", int'(stall_cnt), 0);

        @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_sched.md
HAZARD_SCHED -- requirements
Module: hazard_sched

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: rst  in  1  reset, synchronous, active-low (rst=0 resets on clk rise).
REQ-003 SHALL have ports: id_valid  in  1  decode holds a real instruction.
REQ-004 SHALL have ports: id_rs, id_rt  in  3 each  decode source register selects.
REQ-005 SHALL have ports: id_rs_used, id_rt_used  in  1 each  source actually read.
REQ-006 SHALL have ports: id_regwrt, id_memread  in  1 each  decode writes RD / is a load.
REQ-007 SHALL have ports: id_rd  in  3  decode destination register.
REQ-008 SHALL have ports: id_branch, id_halt  in  1 each  decode is branch/jump / HALT.
REQ-009 SHALL have ports: br_resolve  in  1  execute has resolved the outstanding branch.
REQ-010 SHALL have ports: nop_mech  out  1  force decode control to NOP.
REQ-011 SHALL have ports: pc_hold  out  1  freeze PC and fetch/decode register.
REQ-012 SHALL have ports: if_flush  out  1  squash the fetched instruction.
REQ-013 SHALL have ports: halted  out  1  pipeline drained after HALT.
REQ-014 SHALL have ports: err  out  1  sticky branch-timeout error.
REQ-015 SHALL have ports: stall_cnt  out  16  saturating count of RAW-stall cycles.

Function
REQ-016 SHALL keep a 3-entry scoreboard shift pipe {v, rd, ld}: stage1 to stage3, shifted every cycle.
REQ-017 SHALL load stage1 with {id_valid&id_regwrt&~hazard&state==RUN, id_rd, id_memread}; otherwise insert a bubble (v=0).
REQ-018 SHALL treat stage3 as covered by register-file bypass; hazard compares stage1 and stage2 only.
REQ-019 SHALL assert hazard combinationally when id_valid & state==RUN and, for some used source s, stage k has v=1 and rd==s.
REQ-020 SHALL drive nop_mech=1 and pc_hold=1 in the same cycle as hazard, with zero latency.
REQ-021 SHALL implement states RUN, BR_WAIT, DRAIN, HALTED.
REQ-022 RUN transitions: hazard, then stay in RUN. Else id_halt, then DRAIN. Else id_branch, then BR_WAIT. Priority is hazard > halt > branch.
REQ-023 BR_WAIT: nop_mech=1, if_flush=1, pc_hold=0. On br_resolve, return to RUN next cycle.
REQ-024 BR_WAIT SHALL set err if 7 cycles elapse without br_resolve, then force RUN.
REQ-025 A br_resolve arriving in the BR_WAIT entry cycle SHALL be honoured.
REQ-026 DRAIN: nop_mech=1, pc_hold=1. After 3 cycles (scoreboard empty), go to HALTED.
REQ-027 HALTED: halted=1, nop_mech=1, pc_hold=1. Held until reset.
REQ-028 stall_cnt SHALL increment on every hazard cycle and saturate at 16'hFFFF, never wrapping.
REQ-029 In RUN with no hazard, outputs SHALL be nop_mech=0, pc_hold=0, if_flush=0.

Reset
REQ-030 rst=0 SHALL force: state=RUN, all scoreboard v=0, counters=0, err=0, halted=0, stall_cnt=0.
REQ-031 Reset asserted mid-BR_WAIT or mid-DRAIN SHALL abandon the sequence; first post-reset cycle is RUN with no hazard.

Configuration
REQ-032 With HAZARD_FWD_EN defined, stage1 matches SHALL cause a hazard only when ld=1 (load-use), and stage2 matches SHALL be ignored, because an ALU forwarding path is present.
REQ-033 Without HAZARD_FWD_EN, REQ-019 SHALL apply unchanged.

Structure
REQ-034 Package hazard_pkg SHALL hold the state enum, SB_DEPTH=3, DRAIN_CYCLES=3 and BR_TIMEOUT=7.
REQ-035 The scoreboard pipe and its compare logic SHALL be sub-module hazard_scoreboard; the FSM and counters stay in hazard_sched.

Verification
REQ-036 RAW: write r3, then read r3 on the next cycle. Without the macro, expect nop_mech=pc_hold=1 for 2 cycles and stall_cnt=2.
REQ-037 Load-use with HAZARD_FWD_EN: load r2, then read r2. Expect a 1-cycle stall. Non-load write r2 then read r2 gives 0 stalls.
REQ-038 Branch: id_branch, then br_resolve after 2 cycles. Expect if_flush=1 for 3 cycles, then RUN.
REQ-039 Branch timeout: id_branch with no br_resolve. Expect err=1 after 7 cycles, state back to RUN, err remaining sticky.
REQ-040 Halt: id_halt while writes are in flight. Expect 3 DRAIN cycles, then halted=1. Holding rst=0 for one cycle clears halted.
REQ-041 Saturation: force 70000 hazard cycles. Expect stall_cnt=16'hFFFF.
